iiitb_3bit_rc_dec: RTL and testbench

- Receive-side decoder/checker for the 3-bit one-hot rotating ring-counter sequence 100 -> 010 -> 001 -> 100 on io pads.
- Converts each sampled pattern to a binary index.
- Locks onto the rotation, flags sequence and pattern errors, and counts completed rotations.
- Sits in the user project area. Input is driven from io_in or la_data_in; status goes out to la_data_out/irq.

---
 rtl/iiitb_3bit_rc_dec.sv | 166 ++++++++++++++++
 tb/tb_iiitb_3bit_rc_dec.sv | 125 ++++++++++++
 2 files changed

// File: rtl/iiitb_3bit_rc_dec.sv
// Receive-side decoder/checker for a 3-bit one-hot rotating ring counter.
// Decodes each legal pattern to an index, locks onto the rotation, counts errors and rotations.
module iiitb_3bit_rc_dec #(
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2,
  parameter int ERR_W    = 8,
  parameter int ROT_W    = 8
) (
  input  logic             clk,
  input  logic             ori_n,
  input  logic [2:0]       rc_in,
  input  logic             rc_valid,
  input  logic             err_clr,
  output logic [1:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap,
  output logic [ROT_W-1:0] rot_cnt
);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_C = 4'(MISS_MAX);

  state_t           r_state, w_state;
  logic [2:0]       r_prev, w_prev;
  logic [3:0]       r_good, w_good;
  logic [3:0]       r_miss, w_miss;
  logic [1:0]       r_idx, w_idx;
  logic             r_idx_v, w_idx_v;
  logic             r_err, w_err;
  logic             r_wrap, w_wrap;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt;
  logic [ROT_W-1:0] r_rot, w_rot;

  logic       w_legal;
  logic       w_match;
  logic [2:0] w_succ;
  logic [1:0] w_dec;
  logic [3:0] w_good_inc;
  logic [3:0] w_miss_inc;

  always_comb begin
    w_legal = 1'b0;
    w_dec   = 2'd0;
    case (rc_in)
      3'b100:  begin w_legal = 1'b1; w_dec = 2'd0; end
      3'b010:  begin w_legal = 1'b1; w_dec = 2'd1; end
      3'b001:  begin w_legal = 1'b1; w_dec = 2'd2; end
      default: begin w_legal = 1'b0; w_dec = 2'd0; end
    endcase
  end

  assign w_succ     = {r_prev[0], r_prev[2:1]};
  assign w_match    = (rc_in == w_succ);
  assign w_good_inc = r_good + 4'd1;
  assign w_miss_inc = r_miss + 4'd1;

  always_comb begin
    w_state   = r_state;
    w_prev    = r_prev;
    w_good    = r_good;
    w_miss    = r_miss;
    w_idx     = r_idx;
    w_idx_v   = 1'b0;
    w_err     = 1'b0;
    w_wrap    = 1'b0;
    w_rot     = r_rot;
    if (rc_valid) begin
      if (w_legal) begin
        w_idx   = w_dec;
        w_idx_v = 1'b1;
      end
      case (r_state)
        SEARCH: begin
          if (w_legal) begin
            w_prev  = rc_in;
            w_good  = 4'd0;
            w_state = TRACK;
          end
        end
        TRACK: begin
          if (!w_legal) begin
            w_state = SEARCH;
          end else if (w_match) begin
            w_prev = rc_in;
            w_good = w_good_inc;
            if (w_good_inc == LOCK_C) begin
              w_state = LOCKED;
              w_miss  = 4'd0;
            end
          end else begin
            w_prev = rc_in;
            w_good = 4'd0;
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_prev = rc_in;
            w_miss = 4'd0;
            if (rc_in == 3'b001) begin
              w_wrap = 1'b1;
              w_rot  = r_rot + 1'b1;
            end
          end else begin
            w_err  = 1'b1;
            w_miss = w_miss_inc;
            // Legal miss resyncs; illegal miss flywheels on the expected pattern.
            w_prev = w_legal ? rc_in : w_succ;
            if (w_miss_inc == MISS_C) begin
              w_state = SEARCH;
              w_good  = 4'd0;
            end
          end
        end
        default: w_state = SEARCH;
      endcase
    end
  end

  always_comb begin
    w_err_cnt = r_err_cnt;
    if (err_clr)
      w_err_cnt = w_err ? {{(ERR_W-1){1'b0}}, 1'b1} : '0;
    else if (w_err && !(&r_err_cnt))
      w_err_cnt = r_err_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!ori_n) begin
      r_state   <= SEARCH;
      r_prev    <= 3'b000;
      r_good    <= 4'd0;
      r_miss    <= 4'd0;
      r_idx     <= 2'd0;
      r_idx_v   <= 1'b0;
      r_err     <= 1'b0;
      r_wrap    <= 1'b0;
      r_err_cnt <= '0;
      r_rot     <= '0;
    end else begin
      r_state   <= w_state;
      r_prev    <= w_prev;
      r_good    <= w_good;
      r_miss    <= w_miss;
      r_idx     <= w_idx;
      r_idx_v   <= w_idx_v;
      r_err     <= w_err;
      r_wrap    <= w_wrap;
      r_err_cnt <= w_err_cnt;
      r_rot     <= w_rot;
    end
  end

  assign idx       = r_idx;
  assign idx_valid = r_idx_v;
  assign locked    = (r_state == LOCKED);
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
  assign wrap      = r_wrap;
  assign rot_cnt   = r_rot;

endmodule

// File: tb/tb_iiitb_3bit_rc_dec.sv
// Directed bench for iiitb_3bit_rc_dec with a 2-bit error counter to reach saturation.
module tb_iiitb_3bit_rc_dec;

  localparam int ERR_W = 2;
  localparam int ROT_W = 8;

  logic             clk = 1'b0;
  logic             ori_n = 1'b0;
  logic [2:0]       rc_in = 3'b000;
  logic             rc_valid = 1'b0;
  logic             err_clr = 1'b0;
  logic [1:0]       idx;
  logic             idx_valid;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic             wrap;
  logic [ROT_W-1:0] rot_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  iiitb_3bit_rc_dec #(.LOCK_CNT(3), .MISS_MAX(2), .ERR_W(ERR_W), .ROT_W(ROT_W)) dut (
    .clk(clk), .ori_n(ori_n), .rc_in(rc_in), .rc_valid(rc_valid), .err_clr(err_clr),
    .idx(idx), .idx_valid(idx_valid), .locked(locked), .err(err), .err_cnt(err_cnt),
    .wrap(wrap), .rot_cnt(rot_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one sample, clock it in, and settle just after the edge.
  task automatic smp(input logic v, input logic [2:0] p);
    rc_valid = v;
    rc_in    = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_idx, input logic e_iv,
                         input logic e_lk, input logic e_err, input logic [ERR_W-1:0] e_ec,
                         input logic e_wr, input logic [ROT_W-1:0] e_rot);
    check({tag, ".idx"},       32'(idx),       32'(e_idx));
    check({tag, ".idx_valid"}, 32'(idx_valid), 32'(e_iv));
    check({tag, ".locked"},    32'(locked),    32'(e_lk));
    check({tag, ".err"},       32'(err),       32'(e_err));
    check({tag, ".err_cnt"},   32'(err_cnt),   32'(e_ec));
    check({tag, ".wrap"},      32'(wrap),      32'(e_wr));
    check({tag, ".rot_cnt"},   32'(rot_cnt),   32'(e_rot));
  endtask

  initial begin
    // Reset held two clocks while a legal sample is presented
    ori_n = 1'b0;
    smp(1, 3'b010);
    smp(1, 3'b010);
    chk_all("reset", 2'd0, 0, 0, 0, 2'd0, 0, 8'd0);
    ori_n = 1'b1;
    smp(1, 3'b010);
    chk_all("post_reset", 2'd1, 1, 0, 0, 2'd0, 0, 8'd0);

    // Lock and wrap: 100 resets TRACK, then three successors lock
    smp(1, 3'b100); chk_all("lk1", 2'd0, 1, 0, 0, 2'd0, 0, 8'd0);
    smp(1, 3'b010); chk_all("lk2", 2'd1, 1, 0, 0, 2'd0, 0, 8'd0);
    smp(1, 3'b001); chk_all("lk3", 2'd2, 1, 0, 0, 2'd0, 0, 8'd0);
    smp(1, 3'b100); chk_all("lk4", 2'd0, 1, 1, 0, 2'd0, 0, 8'd0);
    smp(1, 3'b010); chk_all("lk5", 2'd1, 1, 1, 0, 2'd0, 0, 8'd0);
    smp(1, 3'b001); chk_all("lk6", 2'd2, 1, 1, 0, 2'd0, 1, 8'd1);

    // Legal miss resyncs, then illegal + legal miss drop lock
    smp(1, 3'b100); chk_all("er1", 2'd0, 1, 1, 0, 2'd0, 0, 8'd1);
    smp(1, 3'b001); chk_all("er2", 2'd2, 1, 1, 1, 2'd1, 0, 8'd1);
    smp(1, 3'b100); chk_all("er3", 2'd0, 1, 1, 0, 2'd1, 0, 8'd1);
    smp(1, 3'b111); chk_all("er4", 2'd0, 0, 1, 1, 2'd2, 0, 8'd1);
    smp(1, 3'b100); chk_all("er5", 2'd0, 1, 0, 1, 2'd3, 0, 8'd1);

    // Relock, then gaps in rc_valid
    smp(1, 3'b010); chk_all("rl1", 2'd1, 1, 0, 0, 2'd3, 0, 8'd1);
    smp(1, 3'b001); chk_all("rl2", 2'd2, 1, 0, 0, 2'd3, 0, 8'd1);
    smp(1, 3'b100); chk_all("rl3", 2'd0, 1, 0, 0, 2'd3, 0, 8'd1);
    smp(1, 3'b010); chk_all("rl4", 2'd1, 1, 1, 0, 2'd3, 0, 8'd1);
    smp(1, 3'b001); chk_all("gp1", 2'd2, 1, 1, 0, 2'd3, 1, 8'd2);
    smp(0, 3'b100); chk_all("gp2", 2'd2, 0, 1, 0, 2'd3, 0, 8'd2);
    smp(0, 3'b111); chk_all("gp3", 2'd2, 0, 1, 0, 2'd3, 0, 8'd2);
    smp(1, 3'b100); chk_all("gp4", 2'd0, 1, 1, 0, 2'd3, 0, 8'd2);

    // Saturation at 3, clear racing an error, clear alone
    smp(1, 3'b100); chk_all("sat1", 2'd0, 1, 1, 1, 2'd3, 0, 8'd2);
    smp(1, 3'b010); chk_all("sat2", 2'd1, 1, 1, 0, 2'd3, 0, 8'd2);
    err_clr = 1'b1;
    smp(1, 3'b111); chk_all("clr_err", 2'd1, 0, 1, 1, 2'd1, 0, 8'd2);
    smp(0, 3'b111); chk_all("clr_only", 2'd1, 0, 1, 0, 2'd0, 0, 8'd2);
    err_clr = 1'b0;
    smp(1, 3'b100); chk_all("flywheel", 2'd0, 1, 1, 0, 2'd0, 0, 8'd2);

    // Advance rot_cnt to 5
    for (int r = 0; r < 3; r++) begin
      if (r > 0) smp(1, 3'b100);
      smp(1, 3'b010);
      smp(1, 3'b001);
    end
    chk_all("rot5", 2'd2, 1, 1, 0, 2'd0, 1, 8'd5);

    // Mid-lock reset, then relock needs three fresh successors
    ori_n = 1'b0;
    smp(1, 3'b100);
    chk_all("mid_rst", 2'd0, 0, 0, 0, 2'd0, 0, 8'd0);
    ori_n = 1'b1;
    smp(1, 3'b100); chk_all("re1", 2'd0, 1, 0, 0, 2'd0, 0, 8'd0);
    smp(1, 3'b010); chk_all("re2", 2'd1, 1, 0, 0, 2'd0, 0, 8'd0);
    smp(1, 3'b001); chk_all("re3", 2'd2, 1, 0, 0, 2'd0, 0, 8'd0);
    smp(1, 3'b100); chk_all("re4", 2'd0, 1, 1, 0, 2'd0, 0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
